// File: rtl/param_stack.sv
// Parametrised LIFO operand stack with count/full/empty status, overflow/underflow flags and replace-top.
// Optional macro PARAM_STACK_ERR_STICKY_EN makes the error flags sticky until rst or err_clr.
module param_stack #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 32,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    top_idx;
    logic [WIDTH-1:0] top_data;
    logic             do_replace;
    logic             do_push;
    logic             do_pop;
    logic             do_read;
    logic             ovf_evt;
    logic             unf_evt;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign top_idx  = count - CW'(1);
    assign top_data = mem[top_idx[AW-1:0]];

    // push&pop on an empty stack degrades to a plain push; empty implies not full since DEPTH >= 2
    always_comb begin
        do_replace = push && pop && !empty;
        do_push    = push && !full && !do_replace;
        do_pop     = pop && !push && !empty;
        do_read    = do_replace || do_pop || (tos && !push && !pop && !empty);
        ovf_evt    = push && !pop && full;
        unf_evt    = (pop && empty) || (tos && !push && !pop && empty);
    end

    // Storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (do_replace) begin
            mem[top_idx[AW-1:0]] <= d_in;
        end else if (do_push) begin
            mem[count[AW-1:0]] <= d_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            d_out <= '0;
        end else begin
            if (do_push) begin
                count <= count + CW'(1);
            end else if (do_pop) begin
                count <= count - CW'(1);
            end
            if (do_read) begin
                d_out <= top_data;
            end
        end
    end

`ifdef PARAM_STACK_ERR_STICKY_EN
    // err_clr wins over an error arriving in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow || ovf_evt;
            underflow <= underflow || unf_evt;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_evt;
            underflow <= unf_evt;
        end
    end
`endif

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack at DEPTH=4, WIDTH=8; expectations follow PARAM_STACK_ERR_STICKY_EN if defined.
module tb_param_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef PARAM_STACK_ERR_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic             tos;
    logic             err_clr;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int testCount = 0;
    int failCount = 0;

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .err_clr(err_clr),
        .d_in(d_in), .d_out(d_out), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Hold one request for exactly one rising edge, then return to idle
    task automatic applyStimulus(input logic p, input logic po, input logic t, input logic ec,
                                 input logic [WIDTH-1:0] d);
        push = p; pop = po; tos = t; err_clr = ec; d_in = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; tos = 1'b0; err_clr = 1'b0; d_in = '0;
    endtask

    task automatic checkState(input string tag, input int c, input logic [7:0] d, input logic ovf,
                              input logic unf);
        checkOutput({tag, ".count"}, 32'(count), 32'(c));
        checkOutput({tag, ".d_out"}, 32'(d_out), 32'(d));
        checkOutput({tag, ".ovf"}, 32'(overflow), 32'(ovf));
        checkOutput({tag, ".unf"}, 32'(underflow), 32'(unf));
    endtask

    initial begin
        logic [7:0] fillVals [4];
        fillVals[0] = 8'h11; fillVals[1] = 8'h22; fillVals[2] = 8'h33; fillVals[3] = 8'h44;

        rst = 1'b1; push = 1'b0; pop = 1'b0; tos = 1'b0; err_clr = 1'b0; d_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkState("reset", 0, 8'h00, 1'b0, 1'b0);
        checkOutput("reset.empty", 32'(empty), 32'd1);
        checkOutput("reset.full", 32'(full), 32'd0);

        // Fill to DEPTH
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, fillVals[i]);
            checkOutput("fill.count", 32'(count), 32'(i + 1));
        end
        checkOutput("fill.full", 32'(full), 32'd1);
        checkOutput("fill.empty", 32'(empty), 32'd0);

        // Overflow, then idle (pulse vs sticky), then clear
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
        checkState("ovf", 4, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkState("ovf.idle", 4, 8'h00, STICKY, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        checkState("ovf.clr", 4, 8'h00, 1'b0, 1'b0);

        // Drain; the rejected 0x55 must not have landed on top
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            checkState("drain", i, fillVals[i], 1'b0, 1'b0);
        end
        checkOutput("drain.empty", 32'(empty), 32'd1);

        // Underflow on pop and tos; d_out holds, count does not wrap
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkState("unf.pop", 0, 8'h11, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkState("unf.tos", 0, 8'h11, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            checkOutput("unf.idle", 32'(underflow), 32'(STICKY));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("unf.clr", 32'(underflow), 32'd0);
        // err_clr together with a new error: sticky build clears, pulse build reports it
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        checkOutput("unf.clrprio", 32'(underflow), 32'(!STICKY));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Replace-top on [A0,B0]
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'hA0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'hB0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'hC0);
        checkState("rep", 2, 8'hB0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkState("rep.tos", 2, 8'hC0, 1'b0, 1'b0);

        // Replace-top when full never overflows
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'hD0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'hE0);
        checkOutput("repfull.full", 32'(full), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'hF0);
        checkState("repfull", 4, 8'hE0, 1'b0, 1'b0);
        // tos together with push is ignored: push wins and overflows
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h99);
        checkState("tos.ign", 4, 8'hE0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkState("repfull.pop", 3, 8'hF0, 1'b0, 1'b0);

        // Drain D0, C0, A0 then push&pop on empty behaves as push with underflow
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("drain2.d0", 32'(d_out), 32'hD0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("drain2.c0", 32'(d_out), 32'hC0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkState("drain2.a0", 0, 8'hA0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
        checkState("pp.empty", 1, 8'hA0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkState("pp.pop", 0, 8'h77, 1'b0, STICKY);

        // Asynchronous reset mid-burst, checked before the next clock edge
        push = 1'b1; d_in = 8'h01;
        @(posedge clk); #1 d_in = 8'h02;
        @(posedge clk); #1 d_in = 8'h03;
        @(posedge clk); #1;
        checkOutput("burst.count", 32'(count), 32'd3);
        #2 rst = 1'b1;
        #1;
        checkState("async.rst", 0, 8'h00, 1'b0, 1'b0);
        checkOutput("async.empty", 32'(empty), 32'd1);
        push = 1'b0; d_in = '0;
        @(posedge clk); #1 rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkState("post.rst", 0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
